// File: rtl/rsa_modexp_engine_pkg.sv
// Shared definitions for the modular-exponentiation engine: FSM encoding and
// multiply-state timing.
package rsa_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t CHECK  = 3'd1;
    localparam state_t REDUCE = 3'd2;
    localparam state_t SQUARE = 3'd3;
    localparam state_t MULT   = 3'd4;
    localparam state_t FINISH = 3'd5;

    // Cycles spent in one multiply state at the default 16-bit width:
    // launch, one per operand bit, writeback.
    localparam int MUL_CYC = 16 + 2;

    function automatic int mul_cyc(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// Request/response bundle between a requester and the modexp engine.
interface rsa_modexp_engine_if #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16,
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 ct_mode;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 err;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, ct_mode, base, exponent, modulus,
        input  busy, done, result, err, cycle_count
    );

    modport slave (
        input  start, ct_mode, base, exponent, modulus,
        output busy, done, result, err, cycle_count
    );
endinterface

// File: rtl/rsa_modexp_engine_mul.sv
// Blakley interleaved modular multiplier: p = a*b mod n, multiplier scanned MSB
// first, done pulses exactly WIDTH+1 cycles after the start cycle.
module mod_mul_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    // Two guard bits hold 2r + a < 3n without overflow.
    localparam int RW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [RW-1:0]    a_q, a_d, n_q, n_d, r_q, r_d, r_step;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        r_step = (r_q << 1) + (m_q[WIDTH-1] ? a_q : '0);
        if (r_step >= n_q) r_step = r_step - n_q;
        if (r_step >= n_q) r_step = r_step - n_q;

        a_d    = a_q;
        n_d    = n_q;
        r_d    = r_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            a_d   = {2'b00, a};
            n_d   = {2'b00, n};
            m_d   = b;
            r_d   = '0;
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            r_d    = r_step;
            m_d    = m_q << 1;
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            n_q    <= n_d;
            r_q    <= r_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = r_q[WIDTH-1:0];
endmodule

// File: rtl/rsa_modexp_engine.sv
// Modular exponentiation base^exponent mod modulus, left-to-right binary method
// with an optional constant-time square-and-always-multiply schedule.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    rsa_modexp_engine_if.slave bus
);
    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_t               state_q, state_d;
    logic                 ph_q, ph_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    // Bank entry 1 is the live accumulator; entry 0 absorbs discarded products.
    logic [WIDTH-1:0]     acc_q [2];
    logic [WIDTH-1:0]     acc_d [2];
    logic [WIDTH-1:0]     bred_q, bred_d, base_q, base_d, mod_q, mod_d, res_q, res_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic                 ct_q, ct_d, err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mul_start, mul_done, cur_bit;
    logic [WIDTH-1:0]     mul_a, mul_b, mul_p;

    assign cur_bit = exp_q[idx_q];

    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .rst_n(rst_n), .start(mul_start),
        .a(mul_a), .b(mul_b), .n(mod_q), .done(mul_done), .p(mul_p)
    );

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        idx_d     = idx_q;
        acc_d[0]  = acc_q[0];
        acc_d[1]  = acc_q[1];
        bred_d    = bred_q;
        base_d    = base_q;
        mod_d     = mod_q;
        exp_d     = exp_q;
        ct_d      = ct_q;
        res_d     = res_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;

        if (state_q != IDLE && state_q != FINISH && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: if (bus.start) begin
                base_d  = bus.base;
                exp_d   = bus.exponent;
                mod_d   = bus.modulus;
                ct_d    = bus.ct_mode;
                err_d   = 1'b0;
                res_d   = '0;
                cnt_d   = CNT_WIDTH'(1);  // the accept cycle itself counts
                state_d = CHECK;
            end
            CHECK: begin
                if (mod_q < WIDTH'(2)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = FINISH;
                end else begin
                    state_d = REDUCE;
                end
            end
            REDUCE, SQUARE, MULT: begin
                // Multiplicand must be < n; REDUCE uses 1*base so base may exceed n.
                case (state_q)
                    REDUCE:  begin mul_a = WIDTH'(1); mul_b = base_q;   end
                    SQUARE:  begin mul_a = acc_q[1];  mul_b = acc_q[1]; end
                    default: begin mul_a = bred_q;    mul_b = acc_q[1]; end
                endcase
                if (!ph_q) begin
                    mul_start = 1'b1;
                    ph_d      = 1'b1;
                end else if (mul_done) begin
                    ph_d = 1'b0;
                    case (state_q)
                        REDUCE: begin
                            bred_d   = mul_p;
                            acc_d[1] = WIDTH'(1);
                            idx_d    = IDX_W'(EXP_WIDTH - 1);
                            state_d  = SQUARE;
                        end
                        SQUARE: begin
                            acc_d[1] = mul_p;
                            if (ct_q || cur_bit) begin
                                state_d = MULT;
                            end else if (idx_q == '0) begin
                                res_d   = mul_p;
                                state_d = FINISH;
                            end else begin
                                idx_d   = idx_q - 1'b1;
                                state_d = SQUARE;
                            end
                        end
                        default: begin
                            acc_d[cur_bit] = mul_p;
                            if (idx_q == '0) begin
                                res_d   = cur_bit ? mul_p : acc_q[1];
                                state_d = FINISH;
                            end else begin
                                idx_d   = idx_q - 1'b1;
                                state_d = SQUARE;
                            end
                        end
                    endcase
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ph_q     <= 1'b0;
            idx_q    <= '0;
            acc_q[0] <= '0;
            acc_q[1] <= '0;
            bred_q   <= '0;
            base_q   <= '0;
            mod_q    <= '0;
            exp_q    <= '0;
            ct_q     <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            idx_q    <= idx_d;
            acc_q[0] <= acc_d[0];
            acc_q[1] <= acc_d[1];
            bred_q   <= bred_d;
            base_q   <= base_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            ct_q     <= ct_d;
            res_q    <= res_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == FINISH);
    assign bus.result      = res_q;
    assign bus.err         = err_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Scoreboard bench for rsa_modexp_engine: directed corner cases plus random jobs
// checked against an arithmetic reference model.
module tb_rsa_modexp_engine;

    typedef struct {
        logic [15:0] res;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    rsa_modexp_engine_if #(.WIDTH(16), .EXP_WIDTH(16), .CNT_WIDTH(32)) bus ();

    rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Right-to-left square-and-multiply on 64-bit integers.
    function automatic logic [15:0] ref_pow(input logic [15:0] b, input logic [15:0] e,
                                            input logic [15:0] n);
        longint unsigned r, x, m;
        m = longint'(n);
        r = 1 % m;
        x = longint'(b) % m;
        for (int k = 0; k < 16; k++) begin
            if (e[k]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r[15:0];
    endfunction

    function automatic exp_t model(input logic [15:0] b, input logic [15:0] e,
                                   input logic [15:0] n, input logic ct);
        exp_t x;
        if (n < 16'd2) begin
            x.res = '0;
            x.err = 1'b1;
            x.cnt = 32'd2;
        end else begin
            x.res = ref_pow(b, e, n);
            x.err = 1'b0;
            x.cnt = ct ? 32'((1 + 2 * 16) * 18 + 2)
                       : 32'((1 + 16 + $countones(e)) * 18 + 2);
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %0d with no job outstanding", bus.result);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("result", 32'(bus.result), 32'(x.res));
                chk("err", 32'(bus.err), 32'(x.err));
                chk("cycle_count", bus.cycle_count, x.cnt);
            end
        end
    end

    task automatic issue(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                         input logic ct, input bit push);
        @(negedge clk);
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = n;
        bus.ct_mode  = ct;
        bus.start    = 1'b1;
        if (push) sb.push_back(model(b, e, n, ct));
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", k);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                       input logic ct);
        issue(b, e, n, ct, 1'b1);
        wait_done();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_result"}, 32'(bus.result), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_cycle_count"}, bus.cycle_count, 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.ct_mode  = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        run(16'd65, 16'd17, 16'd3233, 1'b0);
        run(16'd2790, 16'd2753, 16'd3233, 1'b1);
        run(16'd65, 16'h0001, 16'd3233, 1'b1);
        run(16'd65, 16'hFFFF, 16'd3233, 1'b1);
        run(16'd65, 16'h8000, 16'd3233, 1'b1);
        run(16'd123, 16'd5, 16'd1, 1'b0);
        run(16'd5, 16'd7, 16'd0, 1'b1);
        run(16'd65, 16'd0, 16'd3233, 1'b0);
        run(16'd65535, 16'd3, 16'd65535, 1'b0);
        run(16'd65534, 16'd2, 16'd65535, 1'b1);
        run(16'd0, 16'd5, 16'd3233, 1'b0);
        run(16'd12345, 16'd777, 16'd1000, 1'b0);

        // Abort mid-job: outputs clear immediately and no done follows.
        issue(16'd2790, 16'd2753, 16'd3233, 1'b1, 1'b0);
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(16'd65, 16'd17, 16'd3233, 1'b1);

        // A second start while busy must not disturb the running job.
        issue(16'd2790, 16'd2753, 16'd3233, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus.base     = 16'd3;
        bus.exponent = 16'd1;
        bus.modulus  = 16'd7;
        bus.ct_mode  = 1'b1;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        chk("idle_after_busy_start", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] rb, re, rn;
            logic        rc;
            rb = 16'($urandom);
            re = 16'($urandom);
            rn = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1))
                                             : 16'($urandom_range(2, 65535));
            rc = 1'($urandom);
            run(rb, re, rn, rc);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
